// File: rtl/mist1032isa_uart_tx_scheduler_pkg.sv
// Shared types and constants for the two-requester UART transmit scheduler.
package mist1032isa_uart_tx_scheduler_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Round-robin pick: on contention the requester that did not win last time goes.
    function automatic logic arb_pick(input logic [NUM_REQ-1:0] valid, input logic last);
        if (valid == 2'b11)
            return ~last;
        return (valid == 2'b10);
    endfunction

endpackage

// File: rtl/mist1032isa_uart_tx_scheduler_if.sv
// Byte request/acknowledge bundle between the requesters and the scheduler.
interface mist1032isa_uart_tx_scheduler_if;
    import mist1032isa_uart_tx_scheduler_pkg::*;

    logic [NUM_REQ-1:0]        iREQ_VALID;
    logic [NUM_REQ*DATA_W-1:0] iREQ_DATA;
    logic [NUM_REQ-1:0]        oREQ_ACK;

    modport master (output iREQ_VALID, output iREQ_DATA, input  oREQ_ACK);
    modport slave  (input  iREQ_VALID, input  iREQ_DATA, output oREQ_ACK);
endinterface

// File: rtl/mist1032isa_uart_tx_baud_gen.sv
// Bit-period timer: latches the divider at frame start and ticks every DIV+1 cycles.
module mist1032isa_uart_tx_baud_gen #(
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  load_i,
    input  logic                  en_i,
    input  logic [BAUD_DIV_W-1:0] div_i,
    output logic                  tick_o
);
    logic [BAUD_DIV_W-1:0] cnt_q, div_q;

    assign tick_o = en_i && (cnt_q == div_q);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            cnt_q <= '0;
            div_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
            div_q <= div_i;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/mist1032isa_uart_tx_scheduler.sv
// Round-robin arbiter in front of a single 8N1 serializer driving the TXD pad.
module mist1032isa_uart_tx_scheduler
    import mist1032isa_uart_tx_scheduler_pkg::*;
#(
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic [BAUD_DIV_W-1:0] iBAUD_DIV,
    input  logic                  iTX_ENA,
    mist1032isa_uart_tx_scheduler_if.slave req,
    output logic                  oUART_TXD,
    output logic                  oTX_BUSY,
    output logic                  oTX_DONE
);
    tx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  byte_q, byte_d;
    logic [2:0]         idx_q, idx_d;
    logic               txd_q, txd_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               done_q, done_d;
    logic               last_q, last_d;
    logic               grant, load, tick;

    assign grant = arb_pick(req.iREQ_VALID, last_q);

    mist1032isa_uart_tx_baud_gen #(.BAUD_DIV_W(BAUD_DIV_W)) u_baud (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .load_i (load),
        .en_i   (oTX_BUSY),
        .div_i  (iBAUD_DIV),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        last_d  = last_q;
        ack_d   = '0;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (iTX_ENA && |req.iREQ_VALID) begin
                    load         = 1'b1;
                    state_d      = ST_START;
                    txd_d        = 1'b0;
                    idx_d        = '0;
                    last_d       = grant;
                    ack_d[grant] = 1'b1;
                    byte_d       = grant ? req.iREQ_DATA[15:8] : req.iREQ_DATA[7:0];
                end
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                idx_d   = '0;
                txd_d   = byte_q[0];
            end
            ST_DATA: if (tick) begin
                if (idx_q == 3'd7) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                    txd_d = byte_q[idx_q + 3'd1];
                end
            end
            ST_STOP: if (tick) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            ack_q   <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign req.oREQ_ACK = ack_q;
    assign oUART_TXD    = txd_q;
    assign oTX_BUSY     = (state_q != ST_IDLE);
    assign oTX_DONE     = done_q;
endmodule
